micro_sequencer: RTL and testbench

- Microprogrammed controller that drives the 16-bit control word of the processing unit (register file + ALU + shifter datapath).
- Holds a loadable microprogram memory, steps a micro-PC, and branches on the registered datapath flags.
- Provides a start/busy/done handshake to the surrounding system and a watchdog that aborts runaway programs.

---
 rtl/micro_sequencer.sv | 134 +++++++++++++
 tb/tb_micro_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/micro_sequencer.sv
// micro_sequencer: microprogrammed controller that issues the 16-bit control
// word for the register-file/ALU/shifter datapath. Holds a writable
// microprogram store, steps a micro-PC, branches on registered datapath flags
// and aborts runaway programs through a step-count watchdog.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; microprogram writes accepted; ctrl = NOP
// RUN   | one micro-instruction per cycle, ctrl = mem[upc].ctrl
// DONE  | single-cycle completion pulse (HALT or watchdog abort)
module micro_sequencer #(
    parameter int ADDR_W    = 4,
    parameter int STEP_W    = 8,
    parameter int MAX_STEPS = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic                prog_we,
    input  logic [ADDR_W-1:0]   prog_addr,
    input  logic [20+ADDR_W:0]  prog_data,
    input  logic [3:0]          state_bits,
    output logic [15:0]         ctrl_word,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [ADDR_W-1:0]   upc
);

    localparam int IW    = 21 + ADDR_W;
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] SEQ_NEXT   = 2'd0;
    localparam logic [1:0] SEQ_JUMP   = 2'd1;
    localparam logic [1:0] SEQ_BRANCH = 2'd2;
    localparam logic [1:0] SEQ_HALT   = 2'd3;

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MAX_STEPS - 1);

    logic [IW-1:0]     mem [0:DEPTH-1];
    logic [1:0]        state, state_nx;
    logic [ADDR_W-1:0] upc_nx, upc_inc;
    logic [STEP_W-1:0] step, step_nx;
    logic              error_nx;

    logic [IW-1:0]     instr;
    logic [15:0]       i_ctrl;
    logic [1:0]        i_seq;
    logic [1:0]        i_cond;
    logic              i_inv;
    logic [ADDR_W-1:0] i_target;
    logic              take;

    // Microprogram store: writes only while idle so a running program is never altered
    always_ff @(posedge clk) begin
        if (prog_we && state == S_IDLE)
            mem[prog_addr] <= prog_data;
    end

    // Asynchronous fetch and field decode of the current micro-instruction
    always_comb begin
        instr    = mem[upc];
        i_ctrl   = instr[15:0];
        i_seq    = instr[17:16];
        i_cond   = instr[19:18];
        i_inv    = instr[20];
        i_target = instr[IW-1:21];
        upc_inc  = upc + 1'b1;
        take     = state_bits[i_cond] ^ i_inv;
    end

    // Next-state, micro-PC, watchdog and error logic
    always_comb begin
        state_nx = state;
        upc_nx   = upc;
        step_nx  = step;
        error_nx = error;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_RUN;
                    upc_nx   = start_addr;
                    step_nx  = '0;
                    error_nx = 1'b0;
                end
            end
            S_RUN: begin
                step_nx = step + 1'b1;
                case (i_seq)
                    SEQ_NEXT:   upc_nx = upc_inc;
                    SEQ_JUMP:   upc_nx = i_target;
                    SEQ_BRANCH: upc_nx = take ? i_target : upc_inc;
                    default:    state_nx = S_DONE;
                endcase
                // Watchdog abort: the last permitted cycle did not halt
                if (i_seq != SEQ_HALT && step == STEP_LAST) begin
                    state_nx = S_DONE;
                    upc_nx   = upc;
                    error_nx = 1'b1;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Sequencer registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            upc   <= '0;
            step  <= '0;
            error <= 1'b0;
        end else begin
            state <= state_nx;
            upc   <= upc_nx;
            step  <= step_nx;
            error <= error_nx;
        end
    end

    // Outputs decoded from state; ctrl is a NOP outside RUN
    always_comb begin
        busy      = (state == S_RUN);
        done      = (state == S_DONE);
        ctrl_word = (state == S_RUN) ? i_ctrl : 16'h0000;
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Testbench for micro_sequencer: table-driven handshake vectors plus directed
// sequences for branching, watchdog, ignored writes, wrap and reset mid-run.
module tb_micro_sequencer;

    localparam logic [1:0] NEXT   = 2'd0;
    localparam logic [1:0] JUMP   = 2'd1;
    localparam logic [1:0] BRANCH = 2'd2;
    localparam logic [1:0] HALT   = 2'd3;

    logic        clk = 1'b0;
    logic        reset, start, prog_we;
    logic [3:0]  start_addr, prog_addr;
    logic [24:0] prog_data;
    logic [3:0]  state_bits;
    logic [15:0] ctrl_word;
    logic        busy, done, error;
    logic [3:0]  upc;

    logic [7:0]  data_in;
    logic [7:0]  r1;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        start;
        logic [3:0]  saddr;
        logic [15:0] ctrl;
        logic        busy;
        logic        done;
        logic        err;
        logic [3:0]  upc;
    } vec_t;

    vec_t vecs [7];

    micro_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .state_bits (state_bits),
        .ctrl_word  (ctrl_word),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .upc        (upc)
    );

    always #5 clk = ~clk;

    // Minimal datapath: load R1 from DATA_in or decrement it, registering the zero flag
    always @(posedge clk) begin
        if (reset) begin
            r1         <= 8'd0;
            state_bits <= 4'd0;
        end else if (ctrl_word == 16'h0080) begin
            r1            <= data_in;
            state_bits[1] <= (data_in == 8'd0);
        end else if (ctrl_word[6:3] == 4'b0110) begin
            r1            <= r1 - 8'd1;
            state_bits[1] <= ((r1 - 8'd1) == 8'd0);
        end
    end

    function automatic logic [24:0] mk(input logic [3:0] tgt, input logic inv,
                                       input logic [1:0] cond, input logic [1:0] seq,
                                       input logic [15:0] ctrl);
        return {tgt, inv, cond, seq, ctrl};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic prog(input logic [3:0] a, input logic [24:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    logic [3:0] br_seq [8];
    int cnt;

    initial begin
        reset = 1'b1; start = 1'b1; start_addr = 4'h7;
        prog_we = 1'b0; prog_addr = 4'h0; prog_data = '0; data_in = 8'd3;

        // Reset held two cycles with start asserted
        tick(); tick();
        chk("rst_ctrl", 32'(ctrl_word), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_error", 32'(error), 32'h0);
        chk("rst_upc", 32'(upc), 32'h0);
        reset = 1'b0; start = 1'b0;
        tick();
        chk("rst_no_run", 32'(busy), 32'h0);

        // Straight-line program, handshake and ignored start in RUN/DONE
        prog(4'd0, mk(4'd0, 1'b0, 2'd0, NEXT, 16'h0080));
        prog(4'd1, mk(4'd0, 1'b0, 2'd0, HALT, 16'h2100));
        vecs[0] = '{1'b1, 4'h0, 16'h0080, 1'b1, 1'b0, 1'b0, 4'h0};
        vecs[1] = '{1'b1, 4'h5, 16'h2100, 1'b1, 1'b0, 1'b0, 4'h1};
        vecs[2] = '{1'b1, 4'h5, 16'h0000, 1'b0, 1'b1, 1'b0, 4'h1};
        vecs[3] = '{1'b1, 4'h5, 16'h0000, 1'b0, 1'b0, 1'b0, 4'h1};
        vecs[4] = '{1'b1, 4'h1, 16'h2100, 1'b1, 1'b0, 1'b0, 4'h1};
        vecs[5] = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 1'b0, 4'h1};
        vecs[6] = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'h1};
        for (int i = 0; i < 7; i++) begin
            start      = vecs[i].start;
            start_addr = vecs[i].saddr;
            tick();
            chk($sformatf("vec%0d_ctrl", i), 32'(ctrl_word), 32'(vecs[i].ctrl));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].done));
            chk($sformatf("vec%0d_error", i), 32'(error), 32'(vecs[i].err));
            chk($sformatf("vec%0d_upc", i), 32'(upc), 32'(vecs[i].upc));
        end
        start = 1'b0;

        // Program write during RUN must be ignored
        start = 1'b1; start_addr = 4'h0;
        tick();
        start = 1'b0;
        prog_we = 1'b1; prog_addr = 4'd1; prog_data = mk(4'd0, 1'b0, 2'd0, HALT, 16'hFFFF);
        tick();
        prog_we = 1'b0;
        chk("we_run_ctrl", 32'(ctrl_word), 32'h2100);
        tick(); tick();
        start = 1'b1; start_addr = 4'h0;
        tick();
        start = 1'b0;
        tick();
        chk("we_rerun_ctrl", 32'(ctrl_word), 32'h2100);
        tick(); tick();

        // Branch loop on zero flag: R1 counts down from 3
        prog(4'd0, mk(4'd0, 1'b0, 2'd0, NEXT, 16'h0080));
        prog(4'd1, mk(4'd0, 1'b0, 2'd0, NEXT, 16'h20B0));
        prog(4'd2, mk(4'd1, 1'b1, 2'd1, BRANCH, 16'h0000));
        prog(4'd3, mk(4'd0, 1'b0, 2'd0, HALT, 16'h0000));
        br_seq = '{4'd0, 4'd1, 4'd2, 4'd1, 4'd2, 4'd1, 4'd2, 4'd3};
        start = 1'b1; start_addr = 4'h0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("br_upc%0d", i), 32'(upc), 32'(br_seq[i]));
            chk($sformatf("br_busy%0d", i), 32'(busy), 32'h1);
            tick();
        end
        chk("br_done", 32'(done), 32'h1);
        chk("br_error", 32'(error), 32'h0);
        tick();

        // Watchdog on a self-jump
        prog(4'd5, mk(4'd5, 1'b0, 2'd0, JUMP, 16'h1200));
        start = 1'b1; start_addr = 4'h5;
        tick();
        start = 1'b0;
        cnt = 0;
        while (busy && cnt < 400) begin
            cnt++;
            tick();
        end
        chk("wd_busy_cycles", 32'(cnt), 32'd255);
        chk("wd_done", 32'(done), 32'h1);
        chk("wd_error", 32'(error), 32'h1);
        chk("wd_upc", 32'(upc), 32'h5);
        tick();
        chk("wd_idle_done", 32'(done), 32'h0);
        chk("wd_err_sticky", 32'(error), 32'h1);
        tick();
        chk("wd_err_sticky2", 32'(error), 32'h1);
        start = 1'b1; start_addr = 4'h0;
        tick();
        start = 1'b0;
        chk("wd_err_clear", 32'(error), 32'h0);
        cnt = 0;
        while (!done && cnt < 50) begin
            cnt++;
            tick();
        end
        chk("wd_rerun_done", 32'(done), 32'h1);
        tick();

        // Wrap from 15 to 0, then reset mid-run
        prog(4'd15, mk(4'd0, 1'b0, 2'd0, NEXT, 16'h0F0F));
        start = 1'b1; start_addr = 4'hF;
        tick();
        start = 1'b0;
        chk("wrap_upc15", 32'(upc), 32'hF);
        chk("wrap_ctrl15", 32'(ctrl_word), 32'h0F0F);
        tick();
        chk("wrap_upc0", 32'(upc), 32'h0);
        chk("wrap_ctrl0", 32'(ctrl_word), 32'h0080);
        reset = 1'b1;
        tick();
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_done", 32'(done), 32'h0);
        chk("mid_rst_ctrl", 32'(ctrl_word), 32'h0);
        chk("mid_rst_upc", 32'(upc), 32'h0);
        reset = 1'b0;
        tick();
        chk("mid_rst_no_done", 32'(done), 32'h0);
        chk("mid_rst_idle", 32'(busy), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
